mem_access_pipe: RTL and testbench
==================================

// Module: mem_access_pipe
// PURPOSE
//  MEM pipeline stage, next-generation replacement for the fixed 3-cycle MEM stage.
//  - Valid/ready handshake on both sides; ALU ops pass through at 1 op/cycle.
//  - Data-memory latency set by parameter; memory is an external fixed-latency port.
//  - Sideband (RegWrite, MemtoReg, Branch, rdist, inst_index, pc...) packed into one CTRL bus.
//  - Supports downstream stall and pipeline flush. Sits between execute and write_back.
// PARAMETERS
//  CTRL_WIDTH      64  width of packed sideband bus carried unmodified EX->WB
//  DATA_ADDR_WIDTH 17  word-address width driven to data memory
//  MEM_LATENCY     2   cycles from read request to valid mem_rdata (legal range 1..15)
// PORTS
//  CLK            in   1                clock
//  reset          in   1                synchronous, active-high
//  flush          in   1                kill in-flight op and output register
//  in_valid       in   1                EX op present
//  in_ready       out  1                stage can accept op this cycle
//  MemRead        in   1                op is a load
//  MemWrite       in   1                op is a store
//  ctrl_in        in   CTRL_WIDTH       sideband from EX
//  alu_result     in   32               ALU result / memory word address
//  register_data  in   32               store data
//  out_valid      out  1                WB op present
//  out_ready      in   1                WB accepts op
//  ctrl_out       out  CTRL_WIDTH       registered sideband
//  alu_result_next out 32               registered alu_result
//  read_data      out  32               registered load data (0 for non-loads)
//  mem_re         out  1                read strobe, 1 cycle
//  mem_we         out  1                write strobe, 1 cycle
//  mem_addr       out  DATA_ADDR_WIDTH  alu_result[DATA_ADDR_WIDTH-1:0]
//  mem_wdata      out  32               register_data
//  mem_rdata      in   32               valid exactly MEM_LATENCY cycles after mem_re
// BEHAVIOUR
//  - FSM states IDLE, WAIT. Counter cnt[3:0].
//  - free = !out_valid | out_ready.  in_ready = (state==IDLE) & free & !flush.
//  - acc = in_valid & in_ready. mem_re = acc & MemRead. mem_we = acc & MemWrite & !MemRead.
//    Both combinational; mem_addr/mem_wdata follow inputs.
//  - acc, non-load (ALU or store):
//    - next cycle out_valid=1; ctrl_out/alu_result_next loaded; read_data=0.
//    - Latency 1; back-to-back accepts allowed.
//    - Stores are posted: write issued on acceptance cycle.
//  - acc, load:
//    - Latch ctrl/alu_result into hold regs; out_valid clears if out_ready; cnt=MEM_LATENCY-1.
//    - Go to WAIT (MEM_LATENCY==1 still enters WAIT for one cycle).
//  - WAIT:
//    - cnt decrements each cycle.
//    - At cnt==0: capture mem_rdata into read_data, load outputs from hold regs, out_valid=1, go to IDLE.
//    - Load latency = MEM_LATENCY+1.
//  - Output hold: out_valid & !out_ready -> all outputs stable, in_ready=0.
//  - flush (highest priority after reset):
//    - Next cycle out_valid=0, state=IDLE, cnt=0.
//    - In-flight load result is discarded (reads are side-effect free).
//    - Stores already issued are not revoked. No accept during flush.
//  - MemRead & MemWrite both set: treated as load, no write issued.
//  - reset mid-WAIT:
//    - Abort without waiting for mem_rdata.
//    - All outputs 0: out_valid, ctrl_out, alu_result_next, read_data, state=IDLE.
//    - in_ready=1 the first cycle after reset deasserts.
// TESTING
//  - ALU stream: 4 ops, alu_result=1..4, out_ready=1 -> out_valid 4 consecutive cycles, values 1..4 in order.
//  - Load, MEM_LATENCY=2: addr 0x10, mem_rdata=0xDEADBEEF at +2 -> read_data=0xDEADBEEF at +3; in_ready=0 for cycles +1..+2.
//  - Store addr 0x20, data 0x55 -> mem_we=1 one cycle, mem_wdata=0x55; out_valid next cycle, read_data=0.
//  - Stall: out_ready=0 for 5 cycles with op valid -> outputs constant, in_ready=0; op released on out_ready=1.
//  - Flush in WAIT cycle 1 -> no out_valid for that load; next op accepted cycle after flush.
//  - reset mid-WAIT -> all outputs 0 next cycle; later mem_rdata ignored.

Source files
------------

// File: rtl/mem_access_pipe.sv
// -----------------------------------------------------------------------------
// mem_access_pipe
//
// MEM pipeline stage sitting between execute and write-back. ALU ops and
// posted stores flow through with one cycle of latency at one op per cycle.
// Loads issue a read to an external fixed-latency data memory and wait
// MEM_LATENCY cycles for the word, giving a load latency of MEM_LATENCY+1.
// The sideband bus (RegWrite, MemtoReg, rdist, pc, ...) is carried unmodified.
//
// Parameters
//   CTRL_WIDTH       width of the packed sideband bus
//   DATA_ADDR_WIDTH  word-address width driven to the data memory
//   MEM_LATENCY      cycles from mem_re to valid mem_rdata (1..15)
//
// Ports
//   CLK, reset        clock, synchronous active-high reset
//   flush             kill in-flight load and output register
//   in_valid/in_ready upstream handshake (EX -> MEM)
//   MemRead/MemWrite  op is a load / store (both set = load)
//   ctrl_in           sideband from EX
//   alu_result        ALU result / memory word address
//   register_data     store data
//   out_valid/out_ready downstream handshake (MEM -> WB)
//   ctrl_out, alu_result_next, read_data  registered outputs to WB
//   mem_re/mem_we     one-cycle read/write strobes
//   mem_addr/mem_wdata address and write data to the data memory
//   mem_rdata         read data, valid MEM_LATENCY cycles after mem_re
// -----------------------------------------------------------------------------
module mem_access_pipe #(
    parameter int CTRL_WIDTH      = 64,
    parameter int DATA_ADDR_WIDTH = 17,
    parameter int MEM_LATENCY     = 2
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       MemRead,
    input  logic                       MemWrite,
    input  logic [CTRL_WIDTH-1:0]      ctrl_in,
    input  logic [31:0]                alu_result,
    input  logic [31:0]                register_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_WIDTH-1:0]      ctrl_out,
    output logic [31:0]                alu_result_next,
    output logic [31:0]                read_data,
    output logic                       mem_re,
    output logic                       mem_we,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Counter preload: cnt reaches 0 in the cycle mem_rdata is valid.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [CTRL_WIDTH-1:0] r_hold_ctrl;
    logic [31:0]           r_hold_alu;
    logic                  r_out_valid;
    logic [CTRL_WIDTH-1:0] r_ctrl_out;
    logic [31:0]           r_alu_out;
    logic [31:0]           r_read_data;

    logic                  w_free;
    logic                  w_in_ready;
    logic                  w_acc;
    logic                  w_load_acc;
    logic                  w_done;

    // The output register can take a new value if empty or being drained.
    assign w_free     = !r_out_valid | out_ready;
    assign w_acc      = in_valid & w_in_ready;
    assign w_load_acc = w_acc & MemRead;
    assign w_done     = (r_state == S_WAIT) && (r_cnt == 4'd0);

    // ---------------------------------------------------------------- FSM ---
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_load_acc) w_state_next = S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == S_IDLE) & w_free & !flush;
        mem_re     = in_valid & w_in_ready & MemRead;
        // A load with MemWrite also set is still only a load.
        mem_we     = in_valid & w_in_ready & MemWrite & !MemRead;
    end

    assign in_ready  = w_in_ready;
    assign mem_addr  = alu_result[DATA_ADDR_WIDTH-1:0];
    assign mem_wdata = register_data;

    // ------------------------------------------------------------ counter ---
    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            r_cnt <= 4'd0;
        end else if (w_load_acc) begin
            r_cnt <= LAT_M1;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------- load hold regs -
    // NOTE: pure datapath holding registers carry no reset; they are only
    // read after being written by an accepted load.
    always_ff @(posedge CLK) begin
        if (w_load_acc) begin
            r_hold_ctrl <= ctrl_in;
            r_hold_alu  <= alu_result;
        end
    end

    // ---------------------------------------------------- output register ---
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_ctrl_out  <= '0;
            r_alu_out   <= '0;
            r_read_data <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_done) begin
            r_out_valid <= 1'b1;
            r_ctrl_out  <= r_hold_ctrl;
            r_alu_out   <= r_hold_alu;
            r_read_data <= mem_rdata;
        end else if (w_acc && !MemRead) begin
            r_out_valid <= 1'b1;
            r_ctrl_out  <= ctrl_in;
            r_alu_out   <= alu_result;
            r_read_data <= '0;
        end else if (out_ready) begin
            // Covers the load-accept cycle too: the previous result drains.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid       = r_out_valid;
    assign ctrl_out        = r_ctrl_out;
    assign alu_result_next = r_alu_out;
    assign read_data       = r_read_data;

endmodule

// File: tb/tb_mem_access_pipe.sv
// Bench for mem_access_pipe: table-driven handshake/strobe vectors, hand
// sequences for latency, stall, flush and reset corners, and a scoreboard
// that predicts every WB output at acceptance time.
module tb_mem_access_pipe;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        reset, flush, in_valid, in_ready, MemRead, MemWrite;
    logic [63:0] ctrl_in, ctrl_out;
    logic [31:0] alu_result, register_data, alu_result_next, read_data;
    logic        out_valid, out_ready, mem_re, mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks;
    int n_fail;

    always #5 CLK = ~CLK;

    mem_access_pipe #(
        .CTRL_WIDTH     (64),
        .DATA_ADDR_WIDTH(17),
        .MEM_LATENCY    (LAT)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .ctrl_in        (ctrl_in),
        .alu_result     (alu_result),
        .register_data  (register_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .ctrl_out       (ctrl_out),
        .alu_result_next(alu_result_next),
        .read_data      (read_data),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // ------------------------------------------------ data memory model ---
    function automatic logic [31:0] mem_word(input logic [16:0] a);
        if (a == 17'h10) return 32'hDEADBEEF;
        return {8'hA5, 7'd0, a};
    endfunction

    logic        rd_v [LAT];
    logic [16:0] rd_a [LAT];

    initial begin
        for (int i = 0; i < LAT; i++) begin
            rd_v[i] = 1'b0;
            rd_a[i] = '0;
        end
    end

    always @(posedge CLK) begin
        for (int i = LAT - 1; i > 0; i--) begin
            rd_v[i] <= rd_v[i-1];
            rd_a[i] <= rd_a[i-1];
        end
        rd_v[0] <= mem_re;
        rd_a[0] <= mem_addr;
    end

    // Garbage outside the valid window so a mistimed capture shows up.
    always_comb mem_rdata = rd_v[LAT-1] ? mem_word(rd_a[LAT-1]) : 32'hBAD0BAD0;

    // ------------------------------------------------------------ helpers ---
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic ordy);
        in_valid      = v;
        MemRead       = rd;
        MemWrite      = wr;
        alu_result    = alu;
        register_data = wd;
        ctrl_in       = {~alu, alu};
        out_ready     = ordy;
    endtask

    // --------------------------------------------------------- scoreboard ---
    typedef struct {
        logic [63:0] ctrl;
        logic [31:0] alu;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    always @(negedge CLK) begin
        exp_t e;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got output alu %0h, expected none", alu_result_next);
                end else begin
                    e = sb.pop_front();
                    check("sb_ctrl", ctrl_out, e.ctrl);
                    check("sb_alu", {32'd0, alu_result_next}, {32'd0, e.alu});
                    check("sb_rdata", {32'd0, read_data}, {32'd0, e.rd});
                end
            end
            if (in_valid && in_ready) begin
                e.ctrl = ctrl_in;
                e.alu  = alu_result;
                e.rd   = MemRead ? mem_word(alu_result[16:0]) : 32'd0;
                sb.push_back(e);
            end
        end
    end

    // ------------------------------------------------------- vector table ---
    typedef struct {
        logic        v, rd, wr;
        logic [31:0] alu, wd;
        logic        ordy;
        logic        exp_ready, exp_re, exp_we;
    } vec_t;

    localparam int NV = 16;
    vec_t vt[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        drive(0, 0, 0, 0, 0, 1);

        //          v  rd wr alu        wd        ordy rdy re we
        vt[0]  = '{1, 0, 0, 32'h1,     32'h0,    1,   1,  0, 0};
        vt[1]  = '{1, 0, 0, 32'h2,     32'h0,    1,   1,  0, 0};
        vt[2]  = '{1, 0, 0, 32'h3,     32'h0,    1,   1,  0, 0};
        vt[3]  = '{1, 0, 0, 32'h4,     32'h0,    1,   1,  0, 0};
        vt[4]  = '{1, 0, 1, 32'h20,    32'h55,   1,   1,  0, 1};
        vt[5]  = '{1, 1, 0, 32'h10,    32'h0,    1,   1,  1, 0};
        vt[6]  = '{1, 0, 0, 32'h30,    32'h0,    1,   0,  0, 0};
        vt[7]  = '{1, 0, 0, 32'h30,    32'h0,    1,   0,  0, 0};
        vt[8]  = '{1, 0, 0, 32'h30,    32'h0,    1,   1,  0, 0};
        vt[9]  = '{1, 1, 1, 32'h40,    32'h99,   1,   1,  1, 0};
        vt[10] = '{0, 0, 0, 32'h0,     32'h0,    1,   0,  0, 0};
        vt[11] = '{0, 0, 0, 32'h0,     32'h0,    1,   0,  0, 0};
        vt[12] = '{0, 0, 0, 32'h0,     32'h0,    1,   1,  0, 0};
        vt[13] = '{1, 0, 1, 32'h50,    32'h66,   0,   1,  0, 1};
        vt[14] = '{1, 0, 0, 32'h60,    32'h0,    0,   0,  0, 0};
        vt[15] = '{1, 0, 0, 32'h60,    32'h0,    1,   1,  0, 0};

        // ---- reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ctrl_out", ctrl_out, 64'd0);
        check("rst_alu_next", {32'd0, alu_result_next}, 64'd0);
        check("rst_read_data", {32'd0, read_data}, 64'd0);
        reset = 1'b0;
        @(negedge CLK);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        step();

        // ---- table
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].v, vt[i].rd, vt[i].wr, vt[i].alu, vt[i].wd, vt[i].ordy);
            @(negedge CLK);
            check($sformatf("tbl%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vt[i].exp_ready});
            check($sformatf("tbl%0d_mem_re", i), {63'd0, mem_re}, {63'd0, vt[i].exp_re});
            check($sformatf("tbl%0d_mem_we", i), {63'd0, mem_we}, {63'd0, vt[i].exp_we});
            if (vt[i].exp_re || vt[i].exp_we)
                check($sformatf("tbl%0d_mem_addr", i), {47'd0, mem_addr}, {47'd0, vt[i].alu[16:0]});
            if (vt[i].exp_we)
                check($sformatf("tbl%0d_mem_wdata", i), {32'd0, mem_wdata}, {32'd0, vt[i].wd});
            step();
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        check("tbl_drain", 64'(sb.size()), 64'd0);
        repeat (2) step();

        // ---- ALU stream: 4 consecutive outputs 1..4
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0, 32'(k), 0, 1);
            @(negedge CLK);
            if (k > 1) begin
                check("alu_stream_valid", {63'd0, out_valid}, 64'd1);
                check("alu_stream_value", {32'd0, alu_result_next}, 64'(k - 1));
            end
            step();
        end
        drive(0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        check("alu_stream_valid", {63'd0, out_valid}, 64'd1);
        check("alu_stream_value", {32'd0, alu_result_next}, 64'd4);
        step();
        @(negedge CLK);
        check("alu_stream_end", {63'd0, out_valid}, 64'd0);
        step();

        // ---- load latency with an ALU op waiting behind it
        drive(1, 1, 0, 32'h10, 0, 1);
        @(negedge CLK);
        check("ld_mem_re", {63'd0, mem_re}, 64'd1);
        check("ld_mem_addr", {47'd0, mem_addr}, 64'h10);
        step();
        drive(1, 0, 0, 32'h77, 0, 1);
        for (int j = 1; j <= 2; j++) begin
            @(negedge CLK);
            check($sformatf("ld_wait%0d_in_ready", j), {63'd0, in_ready}, 64'd0);
            check($sformatf("ld_wait%0d_out_valid", j), {63'd0, out_valid}, 64'd0);
            step();
        end
        @(negedge CLK);
        check("ld_out_valid", {63'd0, out_valid}, 64'd1);
        check("ld_read_data", {32'd0, read_data}, 64'hDEADBEEF);
        check("ld_in_ready_after", {63'd0, in_ready}, 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        check("ld_follow_alu", {32'd0, alu_result_next}, 64'h77);
        check("ld_follow_rdata", {32'd0, read_data}, 64'd0);
        step();

        // ---- posted store
        drive(1, 0, 1, 32'h20, 32'h55, 1);
        @(negedge CLK);
        check("st_mem_we", {63'd0, mem_we}, 64'd1);
        check("st_mem_re", {63'd0, mem_re}, 64'd0);
        check("st_mem_wdata", {32'd0, mem_wdata}, 64'h55);
        check("st_mem_addr", {47'd0, mem_addr}, 64'h20);
        step();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        check("st_mem_we_drop", {63'd0, mem_we}, 64'd0);
        check("st_out_valid", {63'd0, out_valid}, 64'd1);
        check("st_read_data", {32'd0, read_data}, 64'd0);
        step();

        // ---- downstream stall for 5 cycles with a store waiting
        drive(1, 0, 0, 32'hA1, 0, 0);
        step();
        drive(1, 0, 1, 32'hB2, 32'hB3, 0);
        for (int j = 0; j < 5; j++) begin
            @(negedge CLK);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_alu_next", {32'd0, alu_result_next}, 64'hA1);
            check("stall_ctrl_out", ctrl_out, {~32'hA1, 32'hA1});
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_mem_we", {63'd0, mem_we}, 64'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge CLK);
        check("stall_release_ready", {63'd0, in_ready}, 64'd1);
        check("stall_release_we", {63'd0, mem_we}, 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        check("stall_next_alu", {32'd0, alu_result_next}, 64'hB2);
        step();

        // ---- flush in the first WAIT cycle
        drive(1, 1, 0, 32'h24, 0, 1);
        step();
        drive(1, 0, 0, 32'hC3, 0, 1);
        flush = 1'b1;
        @(negedge CLK);
        check("fl_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        flush = 1'b0;
        @(negedge CLK);
        check("fl_out_valid", {63'd0, out_valid}, 64'd0);
        check("fl_accept", {63'd0, in_ready}, 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        check("fl_next_valid", {63'd0, out_valid}, 64'd1);
        check("fl_next_alu", {32'd0, alu_result_next}, 64'hC3);
        check("fl_next_rdata", {32'd0, read_data}, 64'd0);
        step();
        @(negedge CLK);
        check("fl_no_load", {63'd0, out_valid}, 64'd0);
        step();

        // ---- reset mid-WAIT
        drive(1, 0, 0, 32'hE1, 0, 1);
        step();
        drive(1, 1, 0, 32'h28, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge CLK);
        check("rw_out_valid", {63'd0, out_valid}, 64'd0);
        check("rw_ctrl_out", ctrl_out, 64'd0);
        check("rw_alu_next", {32'd0, alu_result_next}, 64'd0);
        check("rw_read_data", {32'd0, read_data}, 64'd0);
        check("rw_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        for (int j = 0; j < 3; j++) begin
            @(negedge CLK);
            check("rw_ignored", {63'd0, out_valid}, 64'd0);
            step();
        end

        check("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
